// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, default reset PC and the
// fetch FSM state type.
package instr_fetch_unit_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word that arrived while decode was stalled.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   load_i               capture {instr_i, pc_i} and mark valid
//   drain_i              entry consumed, mark invalid
//   flush_i              discard entry (wins over load/drain)
//   instr_i, pc_i        word and its PC to capture
//   instr_o, pc_o        held word and PC
//   valid_o              entry holds a word
module fetch_skid_buf
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding request at a time to instruction
// memory, buffers one word across a decode stall and drives the IF/ID register. Redirects from
// execute flush buffered and in-flight fetches.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imem_req, imem_addr         registered request pulse and word-aligned address
//   imem_rdata, imem_rvalid     response word and strobe
//   id_stall                    decode cannot accept; IF/ID holds
//   redirect, redirect_pc       taken branch/jump and its target
//   if_instr, if_pc, if_valid   IF/ID pipeline register
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  input  logic            id_stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d, imem_addr_q, imem_addr_d;
  logic            kill_q, kill_d, imem_req_q, imem_req_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            if_valid_q, if_valid_d;

  logic            buf_load, buf_drain, buf_flush, buf_valid;
  logic [31:0]     buf_instr;
  logic [XLEN-1:0] buf_pc;

  logic [XLEN-1:0] redirect_tgt, pc_inc;
  logic            unused_rpc_lsbs;

  assign redirect_tgt    = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc          = pc_q + XLEN'(4);
  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  fetch_skid_buf #(
    .XLEN (XLEN)
  ) u_skid_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .flush_i (buf_flush),
    .instr_i (imem_rdata),
    .pc_i    (req_pc_q),
    .instr_o (buf_instr),
    .pc_o    (buf_pc),
    .valid_o (buf_valid)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    req_pc_d   = req_pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    buf_load   = 1'b0;
    buf_drain  = 1'b0;
    buf_flush  = 1'b0;

    // No new word this cycle: hold under stall, otherwise insert a bubble.
    if (!id_stall) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // The request raised on entry to IDLE is now in flight. Without one (only right after
        // reset) stay here so a request is raised; rvalid is ignored in this state.
        if (imem_req_q) begin
          state_d = StWait;
          kill_d  = redirect;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = StIdle;
          end else if (!if_valid_q || !id_stall) begin
            if_instr_d = imem_rdata;
            if_pc_d    = req_pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_inc;
            state_d    = StIdle;
          end else begin
            buf_load = 1'b1;
            pc_d     = pc_inc;
            state_d  = StHold;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      StHold: begin
        if (!id_stall) begin
          if_instr_d = buf_instr;
          if_pc_d    = buf_pc;
          if_valid_d = buf_valid;
          buf_drain  = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect wins over everything, including stall.
    if (redirect) begin
      pc_d       = redirect_tgt;
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      buf_flush  = 1'b1;
      buf_load   = 1'b0;
      buf_drain  = 1'b0;
      if (state_q == StHold) begin
        state_d = StIdle;
      end
    end

    // Entering (or staying in) IDLE raises the registered request for pc_d.
    imem_req_d  = (state_d == StIdle);
    imem_addr_d = imem_req_d ? pc_d : imem_addr_q;
    if (imem_req_d) begin
      req_pc_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      req_pc_q    <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      if_instr_q  <= NOP_INSTR;
      if_pc_q     <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      req_pc_q    <= req_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_valid  = if_valid_q;

endmodule
